// File: rtl/int_entry_seq_if.sv
// Bundle of core-register, interrupt-block and data-memory signals seen by int_entry_seq.
// master = sequencer side, slave = core/interrupt block/memory side.
interface int_entry_seq_if;
  logic        REQ;
  logic [15:0] ADDRInt;
  logic        BOUNDARY;
  logic        RTI_EXEC;
  logic [15:0] PC;
  logic [15:0] SR;
  logic [15:0] SP;
  logic [15:0] MEM_RDATA;
  logic        MEM_RDY;
  logic        HOLD;
  logic [15:0] MEM_ADDR;
  logic [15:0] MEM_WDATA;
  logic        MEM_WE;
  logic        MEM_RE;
  logic        PC_LD;
  logic        SR_LD;
  logic        SP_LD;
  logic [15:0] PC_OUT;
  logic [15:0] SR_OUT;
  logic [15:0] SP_OUT;
  logic        RTI;
  logic [3:0]  DEPTH;

  modport master (
    input  REQ, ADDRInt, BOUNDARY, RTI_EXEC, PC, SR, SP, MEM_RDATA, MEM_RDY,
    output HOLD, MEM_ADDR, MEM_WDATA, MEM_WE, MEM_RE, PC_LD, SR_LD, SP_LD,
           PC_OUT, SR_OUT, SP_OUT, RTI, DEPTH
  );

  modport slave (
    output REQ, ADDRInt, BOUNDARY, RTI_EXEC, PC, SR, SP, MEM_RDATA, MEM_RDY,
    input  HOLD, MEM_ADDR, MEM_WDATA, MEM_WE, MEM_RE, PC_LD, SR_LD, SP_LD,
           PC_OUT, SR_OUT, SP_OUT, RTI, DEPTH
  );
endinterface

// File: rtl/int_entry_seq.sv
// Interrupt entry/return sequencer: pushes SR/PC and vectors, or pops PC/SR on RTI.
// Latency: 4 cycles accept-to-IDLE with MEM_RDY=1, +1 per MEM_RDY=0 cycle; HOLD stalls the core.
// Optional nesting-depth counter enabled by INT_NEST_CNT_EN.
module int_entry_seq #(
  parameter int SR_GIE_BIT = 3
) (
  input  logic            CLK,
  input  logic            RESET,
  int_entry_seq_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PUSH_SR = 3'd1;
  localparam logic [2:0] S_PUSH_PC = 3'd2;
  localparam logic [2:0] S_VECTOR  = 3'd3;
  localparam logic [2:0] S_POP_PC  = 3'd4;
  localparam logic [2:0] S_POP_SR  = 3'd5;
  localparam logic [2:0] S_RETURN  = 3'd6;

  localparam logic [15:0] GIE_MASK = 16'h0001 << SR_GIE_BIT;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [15:0] pc_lat;
  logic [15:0] sr_lat;
  logic [15:0] sp_lat;
  logic [15:0] vec_lat;
  logic [15:0] pc_pop;
  logic        accept;
  logic        enter_done;
  logic        pop_done;

  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;

  logic        pc_ld;
  logic        sr_ld;
  logic        sp_ld;
  logic        rti;
  logic [15:0] pc_out;
  logic [15:0] sr_out;
  logic [15:0] sp_out;

  assign accept     = (state == S_IDLE) && bus.BOUNDARY && (bus.REQ || bus.RTI_EXEC);
  assign enter_done = (state == S_PUSH_PC) && bus.MEM_RDY;
  assign pop_done   = (state == S_POP_SR) && bus.MEM_RDY;

  // The core must freeze already in the accept cycle, so HOLD cannot wait for the state flop.
  assign bus.HOLD = (state != S_IDLE) || accept;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.BOUNDARY) begin
          if (bus.RTI_EXEC) begin
            state_nxt = S_POP_PC;
          end else if (bus.REQ) begin
            state_nxt = S_PUSH_SR;
          end
        end
      end
      S_PUSH_SR: if (bus.MEM_RDY) state_nxt = S_PUSH_PC;
      S_PUSH_PC: if (bus.MEM_RDY) state_nxt = S_VECTOR;
      S_VECTOR:  state_nxt = S_IDLE;
      S_POP_PC:  if (bus.MEM_RDY) state_nxt = S_POP_SR;
      S_POP_SR:  if (bus.MEM_RDY) state_nxt = S_RETURN;
      S_RETURN:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Stack port decodes only from the state and the latched registers, so it is stable across waits.
  always_comb begin
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state)
      S_PUSH_SR: begin
        mem_addr  = sp_lat - 16'd1;
        mem_wdata = sr_lat;
        mem_we    = 1'b1;
      end
      S_PUSH_PC: begin
        mem_addr  = sp_lat - 16'd2;
        mem_wdata = pc_lat;
        mem_we    = 1'b1;
      end
      S_POP_PC: begin
        mem_addr = sp_lat;
        mem_re   = 1'b1;
      end
      S_POP_SR: begin
        mem_addr = sp_lat + 16'd1;
        mem_re   = 1'b1;
      end
      default: begin
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= S_IDLE;
      pc_lat  <= 16'h0000;
      sr_lat  <= 16'h0000;
      sp_lat  <= 16'h0000;
      vec_lat <= 16'h0000;
      pc_pop  <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (accept) begin
        pc_lat <= bus.PC;
        sr_lat <= bus.SR;
        sp_lat <= bus.SP;
        if (!bus.RTI_EXEC) begin
          vec_lat <= bus.ADDRInt;
        end
      end
      if ((state == S_POP_PC) && bus.MEM_RDY) begin
        pc_pop <= bus.MEM_RDATA;
      end
    end
  end

  // Strobes are set on the edge entering VECTOR/RETURN so they are clean flop outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_ld  <= 1'b0;
      sr_ld  <= 1'b0;
      sp_ld  <= 1'b0;
      rti    <= 1'b0;
      pc_out <= 16'h0000;
      sr_out <= 16'h0000;
      sp_out <= 16'h0000;
    end else begin
      pc_ld <= enter_done || pop_done;
      sr_ld <= enter_done || pop_done;
      sp_ld <= enter_done || pop_done;
      rti   <= pop_done;
      if (enter_done) begin
        pc_out <= vec_lat;
        sr_out <= sr_lat & ~GIE_MASK;
        sp_out <= sp_lat - 16'd2;
      end else if (pop_done) begin
        pc_out <= pc_pop;
        sr_out <= bus.MEM_RDATA;
        sp_out <= sp_lat + 16'd2;
      end
    end
  end

`ifdef INT_NEST_CNT_EN
  logic [3:0] depth;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      depth <= 4'd0;
    end else if (enter_done) begin
      if (depth != 4'd15) depth <= depth + 4'd1;
    end else if (pop_done) begin
      if (depth != 4'd0) depth <= depth - 4'd1;
    end
  end

  assign bus.DEPTH = depth;
`else
  assign bus.DEPTH = 4'd0;
`endif

  assign bus.MEM_ADDR  = mem_addr;
  assign bus.MEM_WDATA = mem_wdata;
  assign bus.MEM_WE    = mem_we;
  assign bus.MEM_RE    = mem_re;
  assign bus.PC_LD     = pc_ld;
  assign bus.SR_LD     = sr_ld;
  assign bus.SP_LD     = sp_ld;
  assign bus.RTI       = rti;
  assign bus.PC_OUT    = pc_out;
  assign bus.SR_OUT    = sr_out;
  assign bus.SP_OUT    = sp_out;

endmodule

// File: tb/tb_int_entry_seq.sv
// Directed bench for int_entry_seq: entry, return, wait states, priority, reset abort, nesting depth.
module tb_int_entry_seq;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  int_entry_seq_if bus ();

  int_entry_seq #(.SR_GIE_BIT(3)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    bus.REQ      = 1'b0;
    bus.BOUNDARY = 1'b0;
    bus.RTI_EXEC = 1'b0;
    bus.MEM_RDY  = 1'b1;
    bus.PC       = 16'hDEAD;
    bus.SR       = 16'hBEEF;
    bus.SP       = 16'h1234;
    bus.ADDRInt  = 16'h5555;
  endtask

  // exp_sp is the hand-computed new SP; the pushes land at exp_sp+1 then exp_sp.
  task automatic run_entry(input logic [15:0] pc, input logic [15:0] sr, input logic [15:0] sp,
                           input logic [15:0] vec, input logic [15:0] exp_sr, input logic [15:0] exp_sp);
    bus.PC = pc; bus.SR = sr; bus.SP = sp; bus.ADDRInt = vec;
    bus.REQ = 1'b1; bus.BOUNDARY = 1'b1; bus.MEM_RDY = 1'b1;
    #1;
    chk("acc_hold", bus.HOLD, 1);
    chk("acc_we", bus.MEM_WE, 0);
    tick(); quiet(); #1;
    chk("psr_we", bus.MEM_WE, 1);
    chk("psr_addr", bus.MEM_ADDR, exp_sp + 16'd1);
    chk("psr_dat", bus.MEM_WDATA, sr);
    tick(); #1;
    chk("ppc_we", bus.MEM_WE, 1);
    chk("ppc_addr", bus.MEM_ADDR, exp_sp);
    chk("ppc_dat", bus.MEM_WDATA, pc);
    tick(); #1;
    chk("vec_pc_ld", bus.PC_LD, 1);
    chk("vec_sr_ld", bus.SR_LD, 1);
    chk("vec_sp_ld", bus.SP_LD, 1);
    chk("vec_rti", bus.RTI, 0);
    chk("vec_pc_out", bus.PC_OUT, vec);
    chk("vec_sr_out", bus.SR_OUT, exp_sr);
    chk("vec_sp_out", bus.SP_OUT, exp_sp);
    chk("vec_we", bus.MEM_WE, 0);
    tick(); #1;
    chk("ent_end_ld", bus.PC_LD, 0);
    chk("ent_end_hold", bus.HOLD, 0);
  endtask

  task automatic run_return(input logic [15:0] sp, input logic [15:0] mem_pc, input logic [15:0] mem_sr,
                            input logic [15:0] exp_sp, input logic with_req);
    bus.SP = sp; bus.RTI_EXEC = 1'b1; bus.BOUNDARY = 1'b1; bus.REQ = with_req; bus.MEM_RDY = 1'b1;
    #1;
    chk("racc_hold", bus.HOLD, 1);
    tick(); quiet(); bus.MEM_RDATA = mem_pc; #1;
    chk("ppop_re", bus.MEM_RE, 1);
    chk("ppop_we", bus.MEM_WE, 0);
    chk("ppop_addr", bus.MEM_ADDR, sp);
    tick(); bus.MEM_RDATA = mem_sr; #1;
    chk("spop_re", bus.MEM_RE, 1);
    chk("spop_we", bus.MEM_WE, 0);
    chk("spop_addr", bus.MEM_ADDR, exp_sp - 16'd1);
    tick(); bus.MEM_RDATA = 16'hA5A5; #1;
    chk("ret_rti", bus.RTI, 1);
    chk("ret_pc_ld", bus.PC_LD, 1);
    chk("ret_sr_ld", bus.SR_LD, 1);
    chk("ret_sp_ld", bus.SP_LD, 1);
    chk("ret_pc_out", bus.PC_OUT, mem_pc);
    chk("ret_sr_out", bus.SR_OUT, mem_sr);
    chk("ret_sp_out", bus.SP_OUT, exp_sp);
    chk("ret_re", bus.MEM_RE, 0);
    tick(); #1;
    chk("ret_end_rti", bus.RTI, 0);
    chk("ret_end_hold", bus.HOLD, 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    quiet();
    bus.MEM_RDATA = 16'h0000;
    tick(); tick(); #1;
    chk("rst_hold", bus.HOLD, 0);
    chk("rst_we", bus.MEM_WE, 0);
    chk("rst_re", bus.MEM_RE, 0);
    chk("rst_addr", bus.MEM_ADDR, 16'h0000);
    chk("rst_pc_ld", bus.PC_LD, 0);
    chk("rst_rti", bus.RTI, 0);
    chk("rst_pc_out", bus.PC_OUT, 16'h0000);
    chk("rst_depth", bus.DEPTH, 0);
    rst = 1'b0;
    tick();

    // Test-plan entry, then return with REQ also high (RTI must win, no push).
    run_entry(16'h0100, 16'h1E08, 16'h0800, 16'h0040, 16'h1E00, 16'h07FE);
    run_return(16'h07FE, 16'h0100, 16'h1E08, 16'h0800, 1'b1);

    // REQ without BOUNDARY does nothing.
    bus.REQ = 1'b1; #1;
    chk("nob_hold", bus.HOLD, 0);
    tick(); #1;
    chk("nob_hold2", bus.HOLD, 0);
    chk("nob_we", bus.MEM_WE, 0);
    quiet();

    // Two wait cycles per access: load strobes land in cycle 7.
    bus.PC = 16'h0200; bus.SR = 16'h0008; bus.SP = 16'h1000; bus.ADDRInt = 16'h0080;
    bus.REQ = 1'b1; bus.BOUNDARY = 1'b1; bus.MEM_RDY = 1'b0;
    tick(); quiet();
    for (int i = 1; i <= 6; i++) begin
      bus.MEM_RDY = (i == 3 || i == 6);
      #1;
      chk("ws_we", bus.MEM_WE, 1);
      chk("ws_addr", bus.MEM_ADDR, (i <= 3) ? 16'h0FFF : 16'h0FFE);
      chk("ws_dat", bus.MEM_WDATA, (i <= 3) ? 16'h0008 : 16'h0200);
      chk("ws_no_ld", bus.PC_LD, 0);
      tick();
    end
    #1;
    chk("ws_pc_ld", bus.PC_LD, 1);
    chk("ws_pc_out", bus.PC_OUT, 16'h0080);
    chk("ws_sr_out", bus.SR_OUT, 16'h0000);
    chk("ws_sp_out", bus.SP_OUT, 16'h0FFE);
    tick();

    // Reset while in PUSH_PC abandons the sequence.
    bus.PC = 16'h0300; bus.SR = 16'h0108; bus.SP = 16'h2000; bus.ADDRInt = 16'h00C0;
    bus.REQ = 1'b1; bus.BOUNDARY = 1'b1;
    tick(); quiet(); tick(); #1;
    chk("ab_we", bus.MEM_WE, 1);
    chk("ab_addr", bus.MEM_ADDR, 16'h1FFE);
    rst = 1'b1;
    tick(); #1;
    chk("ab_hold", bus.HOLD, 0);
    chk("ab_we0", bus.MEM_WE, 0);
    chk("ab_addr0", bus.MEM_ADDR, 16'h0000);
    chk("ab_pc_ld", bus.PC_LD, 0);
    chk("ab_rti", bus.RTI, 0);
    chk("ab_depth", bus.DEPTH, 0);
    rst = 1'b0;
    tick(); #1;
    chk("ab_pc_ld2", bus.PC_LD, 0);
    chk("ab_rti2", bus.RTI, 0);

    run_entry(16'h0400, 16'hFFFF, 16'h0001, 16'h0044, 16'hFFF7, 16'hFFFF);
`ifdef INT_NEST_CNT_EN
    chk("depth_a", bus.DEPTH, 1);
    run_entry(16'h0044, 16'hFFF7, 16'hFFFF, 16'h0048, 16'hFFF7, 16'hFFFD);
    chk("depth_b", bus.DEPTH, 2);
    run_return(16'hFFFD, 16'h0044, 16'hFFF7, 16'hFFFF, 1'b0);
    chk("depth_c", bus.DEPTH, 1);
    run_return(16'hFFFF, 16'h0400, 16'hFFFF, 16'h0001, 1'b0);
    chk("depth_d", bus.DEPTH, 0);
    for (int i = 0; i < 16; i++) begin
      run_entry(16'h0500, 16'h0008, 16'h0900, 16'h0060, 16'h0000, 16'h08FE);
    end
    chk("depth_sat", bus.DEPTH, 15);
`else
    chk("depth_off", bus.DEPTH, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
